uart_rx_fifo: RTL and testbench

- Parametrised next-generation UART receiver for the duplex UART subsystem, replacing the fixed 2-bit baud-select receiver.
- Adds a runtime baud divisor, 16x oversampling with majority vote, glitch-rejecting start detection, 1 or 2 stop bits, and an RX FIFO.
- Each FIFO entry stores the received data word with its per-frame parity and framing error bits; a sticky overrun flag covers dropped frames.
- Sits between the serial rx pin and the core-side bus bridge.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_rx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_HI  = 9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers, full/empty flags and occupancy count.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A write into a full FIFO is accepted only when a pop frees a slot on the same edge.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; it is only read through the empty mask below, so reset
    // clears the pointers alone and the array maps onto plain RAM cells.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver with majority-vote sampling, glitch-rejecting start
// detection, optional parity, 1 or 2 stop bits and an RX FIFO with sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          rx,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    parity_type,
    input  logic                          stop_bits,
    input  logic                          rd_en,
    input  logic                          clr_ovr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun_flag,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_active_flag,
    output logic                          rx_done_flag
);
    localparam int EW = DATA_BITS + 2;

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 start_edge;
    logic [DIV_WIDTH-1:0] tick_cnt;
    logic [DIV_WIDTH-1:0] reload;
    logic                 tick;
    logic [3:0]           os_cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_idx;
    logic                 s7;
    logic                 s8;
    logic                 maj;
    logic                 at_mid;
    logic                 at_end;
    logic                 par_odd;
    logic                 par_en;
    logic                 last_stop;
    logic [DATA_BITS-1:0] data_sr;
    logic                 par_err_r;
    logic                 frame_err_r;
    logic                 push;
    logic [EW-1:0]        push_entry;
    logic [EW-1:0]        head;
    logic                 fifo_full;
    logic                 fifo_empty;

    // NOTE: every clocked block uses non-blocking assignments so all flops sample
    // the pre-edge values and the two synchroniser stages stay distinct registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = rx_prev & ~rx_s;

    assign reload = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
    assign tick   = (tick_cnt == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                   tick_cnt <= '0;
        else if ((state == IDLE && start_edge) || tick) tick_cnt <= reload;
        else                                            tick_cnt <= tick_cnt - DIV_WIDTH'(1);
    end

    assign maj       = majority3(s7, s8, rx_s);
    assign at_mid    = tick && (os_cnt == 4'(SAMPLE_HI));
    assign at_end    = tick && (os_cnt == 4'(OVERSAMPLE - 1));
    assign par_odd   = (parity_type == PAR_ODD);
    assign par_en    = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
    assign last_stop = stop_idx | ~stop_bits;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE:    if (start_edge) state_next = START;
            START: begin
                if (at_mid && maj) state_next = IDLE;
                else if (at_end)   state_next = DATA;
            end
            DATA:    if (at_end && bit_cnt == 4'(DATA_BITS - 1)) state_next = par_en ? PARITY : STOP;
            PARITY:  if (at_end) state_next = STOP;
            STOP: begin
                // Leaving at mid-stop keeps a back-to-back start edge visible to IDLE.
                if (at_mid && last_stop) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            os_cnt      <= '0;
            bit_cnt     <= '0;
            stop_idx    <= 1'b0;
            s7          <= 1'b1;
            s8          <= 1'b1;
            data_sr     <= '0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else if (state == IDLE) begin
            os_cnt      <= '0;
            bit_cnt     <= '0;
            stop_idx    <= 1'b0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'(SAMPLE_LO))     s7 <= rx_s;
            if (os_cnt == 4'(SAMPLE_LO + 1)) s8 <= rx_s;
            if (os_cnt == 4'(SAMPLE_HI)) begin
                case (state)
                    DATA:    data_sr   <= {maj, data_sr[DATA_BITS-1:1]};
                    PARITY:  par_err_r <= ((^data_sr) ^ maj) != par_odd;
                    STOP:    if (!maj) frame_err_r <= 1'b1;
                    default: ;
                endcase
            end
            if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                if (state == DATA) bit_cnt  <= bit_cnt + 4'd1;
                if (state == STOP) stop_idx <= 1'b1;
            end
        end
    end

    assign push_entry = {frame_err_r | ~maj, par_err_r, data_sr};

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (rx_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                        overrun_flag <= 1'b0;
        else if (push && fifo_full && !rd_en) overrun_flag <= 1'b1;
        else if (clr_ovr)                    overrun_flag <= 1'b0;
    end

    assign {frame_err, parity_err, rx_data} = head;
    assign rx_valid       = ~fifo_empty;
    assign rx_active_flag = (state != IDLE);
    assign rx_done_flag   = push;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frame table, corner-case sequences,
// and randomized frames scored against a queue-based model of the receiver.
module tb_uart_rx_fifo;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_WIDTH  = 16;

    logic                        clock = 1'b0;
    logic                        reset_n = 1'b0;
    logic                        rx = 1'b1;
    logic [DIV_WIDTH-1:0]        baud_div = 16'd2;
    logic [1:0]                  parity_type = 2'b00;
    logic                        stop_bits = 1'b0;
    logic                        rd_en = 1'b0;
    logic                        clr_ovr = 1'b0;
    logic [DATA_BITS-1:0]        rx_data;
    logic                        rx_valid;
    logic                        parity_err;
    logic                        frame_err;
    logic                        overrun_flag;
    logic [$clog2(FIFO_DEPTH):0] rx_count;
    logic                        rx_active_flag;
    logic                        rx_done_flag;

    uart_rx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rx             (rx),
        .baud_div       (baud_div),
        .parity_type    (parity_type),
        .stop_bits      (stop_bits),
        .rd_en          (rd_en),
        .clr_ovr        (clr_ovr),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .overrun_flag   (overrun_flag),
        .rx_count       (rx_count),
        .rx_active_flag (rx_active_flag),
        .rx_done_flag   (rx_done_flag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [1:0]  ptype;
        logic        two_stop;
        logic        bad_par;
        logic [1:0]  stop_low;
        logic [7:0]  exp_data;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          d0;
    logic        found;
    logic        use_par;
    logic        pbit;
    logic [9:0]  model_q[$];
    logic        model_ovr;
    vec_t        vecs[8];
    logic [7:0]  r_data;
    logic [1:0]  r_ptype;
    logic        r_two;
    logic [1:0]  r_sl;
    logic [15:0] r_div;
    logic        r_perr;
    logic        r_ferr;
    int          psum;

    always @(negedge clock) if (rx_done_flag) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic pb,
                              input logic two_stop, input logic [1:0] stop_low,
                              input logic [15:0] div);
        int bl;
        bl = 16 * ((div == 16'd0) ? 1 : int'(div));
        rx = 1'b0;
        cycles(bl);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = data[i];
            cycles(bl);
        end
        if (par) begin
            rx = pb;
            cycles(bl);
        end
        rx = ~stop_low[0];
        cycles(bl);
        if (two_stop) begin
            rx = ~stop_low[1];
            cycles(bl);
        end
        rx = 1'b1;
    endtask

    task automatic simple_frame(input logic [7:0] data);
        send_frame(data, 1'b0, 1'b0, 1'b0, 2'b00, 16'd2);
        cycles(4);
    endtask

    task automatic check_head(input string name, input logic [9:0] exp);
        check({name, "_valid"}, rx_valid, 1);
        check({name, "_data"}, rx_data, exp[7:0]);
        check({name, "_perr"}, parity_err, exp[8]);
        check({name, "_ferr"}, frame_err, exp[9]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 16'd2, 2'b00, 1'b0, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h6D, 16'd2, 2'b01, 1'b0, 1'b0, 2'b00, 8'h6D, 1'b0, 1'b0};
        vecs[2] = '{8'hAA, 16'd2, 2'b10, 1'b0, 1'b1, 2'b00, 8'hAA, 1'b1, 1'b0};
        vecs[3] = '{8'hB4, 16'd2, 2'b00, 1'b1, 1'b0, 2'b10, 8'hB4, 1'b0, 1'b1};
        vecs[4] = '{8'hB4, 16'd2, 2'b00, 1'b1, 1'b0, 2'b00, 8'hB4, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 16'd0, 2'b11, 1'b0, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b0};
        vecs[6] = '{8'h81, 16'd3, 2'b01, 1'b1, 1'b1, 2'b01, 8'h81, 1'b1, 1'b1};
        vecs[7] = '{8'hFF, 16'd1, 2'b10, 1'b0, 1'b0, 2'b01, 8'hFF, 1'b0, 1'b1};

        #2;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_count", rx_count, 0);
        check("rst_ovr", overrun_flag, 0);
        check("rst_active", rx_active_flag, 0);
        check("rst_done", rx_done_flag, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        cycles(4);

        for (int i = 0; i < 8; i++) begin
            baud_div    = vecs[i].div;
            parity_type = vecs[i].ptype;
            stop_bits   = vecs[i].two_stop;
            use_par     = (vecs[i].ptype == 2'b01) || (vecs[i].ptype == 2'b10);
            pbit        = ((vecs[i].ptype == 2'b01) ? ~(^vecs[i].data) : ^vecs[i].data) ^ vecs[i].bad_par;
            d0          = done_cnt;
            send_frame(vecs[i].data, use_par, pbit, vecs[i].two_stop, vecs[i].stop_low, vecs[i].div);
            cycles(4);
            check($sformatf("tbl%0d_done", i), done_cnt - d0, 1);
            check_head($sformatf("tbl%0d", i), {vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].exp_data});
            pop();
            check($sformatf("tbl%0d_empty", i), rx_valid, 0);
        end

        // Read while empty is ignored.
        pop();
        check("empty_rd_count", rx_count, 0);
        check("empty_rd_valid", rx_valid, 0);

        // Start glitch: 3 ticks low at baud_div=2.
        baud_div = 16'd2; parity_type = 2'b00; stop_bits = 1'b0;
        d0 = done_cnt;
        rx = 1'b0;
        cycles(4);
        check("glitch_active_hi", rx_active_flag, 1);
        cycles(2);
        rx = 1'b1;
        cycles(60);
        check("glitch_active_lo", rx_active_flag, 0);
        check("glitch_count", rx_count, 0);
        check("glitch_done", done_cnt - d0, 0);

        // Overrun: nine frames with no reads.
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) simple_frame(8'(i));
        check("ovr_done", done_cnt - d0, 9);
        check("ovr_count", rx_count, 8);
        check("ovr_flag", overrun_flag, 1);
        check_head("ovr_head", 10'h000);
        clr_ovr = 1'b1;
        cycles(1);
        clr_ovr = 1'b0;
        check("ovr_clr", overrun_flag, 0);
        for (int i = 0; i < 8; i++) begin
            check_head($sformatf("ovr_pop%0d", i), 10'(i));
            pop();
        end
        check("ovr_lost", rx_valid, 0);

        // Full FIFO with a read on the push cycle of the ninth frame.
        for (int i = 0; i < 8; i++) simple_frame(8'h10 + 8'(i));
        check("sim_full_count", rx_count, 8);
        found = 1'b0;
        fork
            send_frame(8'hC8, 1'b0, 1'b0, 1'b0, 2'b00, 16'd2);
            begin
                for (int k = 0; k < 2000 && !found; k++) begin
                    @(negedge clock);
                    if (rx_done_flag) begin
                        rd_en = 1'b1;
                        @(posedge clock);
                        #1 rd_en = 1'b0;
                        found = 1'b1;
                    end
                end
            end
        join
        cycles(4);
        check("sim_done_seen", found, 1);
        check("sim_ovr", overrun_flag, 0);
        check("sim_count", rx_count, 8);
        for (int i = 1; i < 8; i++) begin
            check_head($sformatf("sim_pop%0d", i), 10'h010 + 10'(i));
            pop();
        end
        check_head("sim_tail", 10'h0C8);

        // Reset in the middle of a frame.
        fork
            send_frame(8'h33, 1'b0, 1'b0, 1'b0, 2'b00, 16'd2);
            begin
                cycles(128);
                check("rmid_active_pre", rx_active_flag, 1);
                check("rmid_valid_pre", rx_valid, 1);
                reset_n = 1'b0;
                #1;
                check("rmid_valid", rx_valid, 0);
                check("rmid_count", rx_count, 0);
                check("rmid_data", rx_data, 0);
                check("rmid_active", rx_active_flag, 0);
                check("rmid_done", rx_done_flag, 0);
                check("rmid_ovr", overrun_flag, 0);
                check("rmid_perr", parity_err, 0);
                check("rmid_ferr", frame_err, 0);
            end
        join
        cycles(2);
        reset_n = 1'b1;
        cycles(4);
        simple_frame(8'h5A);
        check("rmid_next_count", rx_count, 1);
        check_head("rmid_next", 10'h05A);
        pop();

        // Randomized frames against the queue model.
        model_q.delete();
        model_ovr = 1'b0;
        for (int n = 0; n < 24; n++) begin
            r_data  = 8'($urandom);
            r_ptype = 2'($urandom_range(0, 3));
            r_two   = 1'($urandom_range(0, 1));
            r_div   = 16'($urandom_range(0, 3));
            r_sl    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pbit    = 1'($urandom_range(0, 1));
            use_par = (r_ptype == 2'b01) || (r_ptype == 2'b10);
            baud_div = r_div; parity_type = r_ptype; stop_bits = r_two;
            d0 = done_cnt;
            send_frame(r_data, use_par, pbit, r_two, r_sl, r_div);
            cycles(4);

            psum   = ($countones(r_data) + int'(pbit)) % 2;
            r_perr = use_par && ((r_ptype == 2'b01) ? (psum != 1) : (psum != 0));
            r_ferr = r_sl[0] | (r_two & r_sl[1]);
            if (model_q.size() == FIFO_DEPTH) model_ovr = 1'b1;
            else model_q.push_back({r_ferr, r_perr, r_data});

            check($sformatf("rnd%0d_done", n), done_cnt - d0, 1);
            check($sformatf("rnd%0d_count", n), rx_count, model_q.size());
            check($sformatf("rnd%0d_ovr", n), overrun_flag, model_ovr);
            if (model_q.size() > 0 && $urandom_range(0, 3) == 0) begin
                check_head($sformatf("rnd%0d", n), model_q[0]);
                void'(model_q.pop_front());
                pop();
            end
            if (model_ovr && $urandom_range(0, 1) == 0) begin
                clr_ovr = 1'b1;
                cycles(1);
                clr_ovr = 1'b0;
                model_ovr = 1'b0;
                check($sformatf("rnd%0d_clr", n), overrun_flag, 0);
            end
        end
        while (model_q.size() > 0) begin
            check_head("drain", model_q[0]);
            void'(model_q.pop_front());
            pop();
        end
        check("drain_empty", rx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
